// File: rtl/bch_pkg.sv
// Shared constants, GF(16) helper functions and FSM state type for the
// BCH(15,7) Chien-search corrector.
package bch_pkg;

  localparam int N = 15;
  localparam int M = 4;
  localparam logic [M:0] PRIM_POLY = 5'b10011;  // x^4 + x + 1

  typedef enum logic [1:0] {IDLE, SOLVE, SEARCH, DONE} state_t;

  function automatic logic [M-1:0] alpha_pow(input logic [3:0] e);
    case (e)
      4'd0:    alpha_pow = 4'h1;
      4'd1:    alpha_pow = 4'h2;
      4'd2:    alpha_pow = 4'h4;
      4'd3:    alpha_pow = 4'h8;
      4'd4:    alpha_pow = 4'h3;
      4'd5:    alpha_pow = 4'h6;
      4'd6:    alpha_pow = 4'hC;
      4'd7:    alpha_pow = 4'hB;
      4'd8:    alpha_pow = 4'h5;
      4'd9:    alpha_pow = 4'hA;
      4'd10:   alpha_pow = 4'h7;
      4'd11:   alpha_pow = 4'hE;
      4'd12:   alpha_pow = 4'hF;
      4'd13:   alpha_pow = 4'hD;
      4'd14:   alpha_pow = 4'h9;
      default: alpha_pow = 4'h1;
    endcase
  endfunction

  // Discrete log; log(0) is undefined and returns 0.
  function automatic logic [3:0] gf_log(input logic [M-1:0] x);
    gf_log = 4'd0;
    for (int k = 0; k < N; k++)
      if (alpha_pow(4'(k)) == x) gf_log = 4'(k);
  endfunction

  function automatic logic [M-1:0] gf_inv(input logic [M-1:0] x);
    case (x)
      4'h1:    gf_inv = 4'h1;
      4'h2:    gf_inv = 4'h9;
      4'h3:    gf_inv = 4'hE;
      4'h4:    gf_inv = 4'hD;
      4'h5:    gf_inv = 4'hB;
      4'h6:    gf_inv = 4'h7;
      4'h7:    gf_inv = 4'h6;
      4'h8:    gf_inv = 4'hF;
      4'h9:    gf_inv = 4'h2;
      4'hA:    gf_inv = 4'hC;
      4'hB:    gf_inv = 4'h5;
      4'hC:    gf_inv = 4'hA;
      4'hD:    gf_inv = 4'h4;
      4'hE:    gf_inv = 4'h3;
      4'hF:    gf_inv = 4'h8;
      default: gf_inv = 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/gf16_mul.sv
// Combinational GF(16) multiplier: carry-less product reduced modulo x^4+x+1.
module gf16_mul
  import bch_pkg::*;
(
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p
);

  localparam int PW = 2 * M - 1;

  logic [PW-1:0] prod;

  always_comb begin
    // NOTE: prod gets its default first, so the loops below cannot infer a latch.
    prod = '0;
    for (int i = 0; i < M; i++)
      if (b[i]) prod = prod ^ (PW'(a) << i);
    for (int k = PW - 1; k >= M; k--)
      if (prod[k]) prod = prod ^ (PW'(PRIM_POLY) << (k - M));
  end

  assign p = prod[M-1:0];

endmodule

// File: rtl/bch_chien_corrector.sv
// BCH(15,7) t=2 corrector: solves the error locator from S1/S3, runs a
// serial Chien search (one position per cycle) and returns the fixed word.
module bch_chien_corrector #(
  parameter int N        = 15,
  parameter int M        = 4,
  parameter bit CHECK_S2 = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] codeword,
  input  logic [M-1:0] S1,
  input  logic [M-1:0] S2,
  input  logic [M-1:0] S3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] corrected,
  output logic [1:0]   err_count,
  output logic         uncorrectable
);
  import bch_pkg::*;

  if (N != bch_pkg::N || M != bch_pkg::M) begin : g_bad_param
    $error("bch_chien_corrector supports only N=15, M=4");
  end

  // Chien step constants: multiply by alpha^14 (alpha^-1) and alpha^13 (alpha^-2).
  function automatic logic [M-1:0] mul_a14(input logic [M-1:0] x);
    return {x[0], x[3], x[2], x[1] ^ x[0]};
  endfunction

  function automatic logic [M-1:0] mul_a13(input logic [M-1:0] x);
    return mul_a14(mul_a14(x));
  endfunction

  state_t       state, state_n;
  logic [N-1:0] cw_q, mask, mask_n, corr_q;
  logic [M-1:0] s1_q, s2_q, s3_q, term1, term2;
  logic [M-1:0] s1_sq, s1_cu, s1_inv, sigma2;
  logic [3:0]   idx;
  logic [1:0]   roots, roots_n, deg, err_q;
  logic         unc_q, in_ready_q;
  logic         s1_zero, s2_bad, early, early_unc, hit, last;

  assign s1_inv = gf_inv(s1_q);

  gf16_mul u_sq  (.a(s1_q),         .b(s1_q),   .p(s1_sq));
  gf16_mul u_cu  (.a(s1_sq),        .b(s1_q),   .p(s1_cu));
  gf16_mul u_sig (.a(s3_q ^ s1_cu), .b(s1_inv), .p(sigma2));

  always_comb begin
    s1_zero   = (s1_q == '0);
    s2_bad    = CHECK_S2 && (s2_q != s1_sq);
    early     = s1_zero || s2_bad;
    early_unc = s1_zero ? (s3_q != '0) : s2_bad;
    hit       = ((4'h1 ^ term1 ^ term2) == '0);
    roots_n   = (hit && roots != 2'd3) ? roots + 2'd1 : roots;
    mask_n    = mask | (N'(hit) << idx);
    last      = (idx == 4'(N - 1));
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid && in_ready_q) state_n = SOLVE;
      SOLVE:   state_n = early ? DONE : SEARCH;
      SEARCH:  if (last) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so an aborted word leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready_q <= 1'b0;
      cw_q       <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      term1      <= '0;
      term2      <= '0;
      idx        <= '0;
      roots      <= '0;
      mask       <= '0;
      deg        <= '0;
      corr_q     <= '0;
      err_q      <= '0;
      unc_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates, so every register samples pre-edge values.
      state      <= state_n;
      in_ready_q <= (state_n == IDLE);
      case (state)
        IDLE: if (in_valid && in_ready_q) begin
          cw_q <= codeword;
          s1_q <= S1;
          s2_q <= S2;
          s3_q <= S3;
        end
        SOLVE: if (early) begin
          corr_q <= cw_q;
          err_q  <= 2'd0;
          unc_q  <= early_unc;
        end else begin
          term1 <= s1_q;
          term2 <= sigma2;
          idx   <= '0;
          roots <= '0;
          mask  <= '0;
          deg   <= (sigma2 != '0) ? 2'd2 : 2'd1;
        end
        SEARCH: begin
          term1 <= mul_a14(term1);
          term2 <= mul_a13(term2);
          idx   <= idx + 4'd1;
          roots <= roots_n;
          mask  <= mask_n;
          if (last) begin
            if (roots_n == deg) begin
              corr_q <= cw_q ^ mask_n;
              err_q  <= deg;
              unc_q  <= 1'b0;
            end else begin
              corr_q <= cw_q;
              err_q  <= 2'd0;
              unc_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (state == DONE);
  assign corrected     = corr_q;
  assign err_count     = err_q;
  assign uncorrectable = unc_q;

endmodule

// File: tb/tb_bch_chien_corrector.sv
// Directed bench for bch_chien_corrector: expected results are queued at
// stimulus time and compared, with latency, when the result handshakes.
module tb_bch_chien_corrector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] codeword;
  logic [3:0]  S1, S2, S3;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] corrected;
  logic [1:0]  err_count;
  logic        uncorrectable;

  bch_chien_corrector dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .codeword(codeword), .S1(S1), .S2(S2), .S3(S3),
    .out_valid(out_valid), .out_ready(out_ready),
    .corrected(corrected), .err_count(err_count), .uncorrectable(uncorrectable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] cw;
    logic [1:0]  err;
    logic        unc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   t_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [14:0] cw, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [14:0] ecw, input logic [1:0] eerr,
                      input logic eunc, input int lat);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    codeword = cw; S1 = a; S2 = b; S3 = c;
    in_valid = 1'b1;
    t_acc = cyc;
    sb.push_back('{ecw, eerr, eunc, lat});
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_busy", 32'(in_ready), 32'd0);
  endtask

  // Waits for a result, holds out_ready low for 'stall' cycles, then handshakes.
  task automatic receive(input int stall);
    exp_t e;
    int n = 0;
    out_ready = (stall == 0);
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      check("out_valid_timeout", 32'(out_valid), 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check("unexpected_output", 32'(out_valid), 32'd0);
      return;
    end
    e = sb.pop_front();
    check("latency", 32'(cyc - t_acc), 32'(e.lat));
    for (int k = 0; k < stall; k++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_corrected", 32'(corrected), 32'(e.cw));
      check("stall_err", 32'(err_count), 32'(e.err));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("corrected", 32'(corrected), 32'(e.cw));
    check("err_count", 32'(err_count), 32'(e.err));
    check("uncorrectable", 32'(uncorrectable), 32'(e.unc));
    @(negedge clk);
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    codeword = '0; S1 = '0; S2 = '0; S3 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_corrected", 32'(corrected), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_uncorr", 32'(uncorrectable), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Zero word: early exit, result at T+2.
    send(15'h0000, 4'h0, 4'h0, 4'h0, 15'h0000, 2'd0, 1'b0, 2);
    receive(0);
    // Single error at bit 3.
    send(15'h0008, 4'h8, 4'hC, 4'hA, 15'h0000, 2'd1, 1'b0, 17);
    receive(0);
    // Double error at bits 0 and 5.
    send(15'h0021, 4'h7, 4'h6, 4'h0, 15'h0000, 2'd2, 1'b0, 17);
    receive(0);
    // S1=0 with S3!=0: uncorrectable, early exit.
    send(15'h1234, 4'h0, 4'h0, 4'h1, 15'h1234, 2'd0, 1'b1, 2);
    receive(0);
    // S2 != S1^2: uncorrectable, early exit.
    send(15'h0055, 4'h1, 4'h2, 4'h0, 15'h0055, 2'd0, 1'b1, 2);
    receive(0);
    // sigma(x)=1+x+alpha^3 x^2 has no roots: search ends uncorrectable.
    send(15'h4321, 4'h1, 4'h1, 4'h9, 15'h4321, 2'd0, 1'b1, 17);
    receive(0);
    // Single error at the last searched position, bit 14.
    send(15'h4000, 4'h9, 4'hD, 4'hF, 15'h0000, 2'd1, 1'b0, 17);
    receive(0);
    // All-ones codeword, zero syndromes: passed through unchanged.
    send(15'h7FFF, 4'h0, 4'h0, 4'h0, 15'h7FFF, 2'd0, 1'b0, 2);
    receive(0);

    // Backpressure: a pending zero word is held off until after the handshake.
    send(15'h0008, 4'h8, 4'hC, 4'hA, 15'h0000, 2'd1, 1'b0, 17);
    codeword = 15'h0000; S1 = 4'h0; S2 = 4'h0; S3 = 4'h0;
    in_valid = 1'b1;
    receive(5);
    t_acc = cyc;
    sb.push_back('{15'h0000, 2'd0, 1'b0, 2});
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_in_ready_busy", 32'(in_ready), 32'd0);
    receive(0);

    // Reset mid-search: the aborted word is dropped, the next decodes cleanly.
    send(15'h0008, 4'h8, 4'hC, 4'hA, 15'h0000, 2'd1, 1'b0, 17);
    while (cyc - t_acc < 8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle_in_ready", 32'(in_ready), 32'd1);
    check("abort_idle_out_valid", 32'(out_valid), 32'd0);
    send(15'h0021, 4'h7, 4'h6, 4'h0, 15'h0000, 2'd2, 1'b0, 17);
    receive(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
